// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU: shift-add multiplier and
// restoring divider, one bit per cycle, with pipeline stall request and a registered result.
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       FUNCT3_EX,
   input  logic [WIDTH-1:0] OP_A,
   input  logic [WIDTH-1:0] OP_B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] RESULT,
   output logic             stall_EX
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_IT   = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    counter_r;
   logic [2:0]       funct3_r;
   logic [WIDTH-1:0] acc_r;      // product high half / partial remainder
   logic [WIDTH-1:0] lo_r;       // multiplier -> product low half / dividend -> quotient
   logic [WIDTH-1:0] opb_r;      // multiplicand / divisor magnitude
   logic [WIDTH-1:0] result_r;
   logic             neg_q_r;
   logic             neg_r_r;
   logic             busy_r;
   logic             done_r;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
      neg_if = neg ? (~v + ONE_W) : v;
   endfunction

   // operand sign decode and magnitude conversion at the accept edge
   logic             a_signed_s, b_signed_s, sign_a_s, sign_b_s;
   logic             is_div_s, div_zero_s, div_ovf_s, special_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s, special_res_s;

   always_comb begin
      a_signed_s = (FUNCT3_EX == 3'b001) || (FUNCT3_EX == 3'b010) ||
                   (FUNCT3_EX == 3'b100) || (FUNCT3_EX == 3'b110);
      b_signed_s = (FUNCT3_EX == 3'b001) || (FUNCT3_EX == 3'b100) || (FUNCT3_EX == 3'b110);
      sign_a_s   = a_signed_s && OP_A[WIDTH-1];
      sign_b_s   = b_signed_s && OP_B[WIDTH-1];
      mag_a_s    = neg_if(OP_A, sign_a_s);
      mag_b_s    = neg_if(OP_B, sign_b_s);
      is_div_s   = FUNCT3_EX[2];
      div_zero_s = is_div_s && (OP_B == ZERO_W);
      div_ovf_s  = is_div_s && !FUNCT3_EX[0] && (OP_A == MIN_NEG_W) && (OP_B == ONES_W);
      special_s  = div_zero_s || div_ovf_s;
      special_res_s = ZERO_W;
      if (div_zero_s) begin
         special_res_s = FUNCT3_EX[1] ? OP_A : ONES_W;
      end else if (FUNCT3_EX[1]) begin
         special_res_s = ZERO_W;
      end else begin
         special_res_s = MIN_NEG_W;
      end
   end

   // one multiply or divide iteration, plus the sign-corrected final result
   logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
   logic               div_ok_s;
   logic [WIDTH-1:0]   acc_nxt_s, lo_nxt_s, final_res_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;

   always_comb begin
      mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opb_r} : {1'b0, ZERO_W});
      div_shift_s = {acc_r, lo_r[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opb_r};
      div_ok_s    = !div_diff_s[WIDTH];
      acc_nxt_s   = ZERO_W;
      lo_nxt_s    = ZERO_W;
      if (funct3_r[2]) begin
         acc_nxt_s = div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
         lo_nxt_s  = {lo_r[WIDTH-2:0], div_ok_s};
      end else begin
         acc_nxt_s = mul_sum_s[WIDTH:1];
         lo_nxt_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end
      prod_s      = {acc_nxt_s, lo_nxt_s};
      prod_fix_s  = neg_q_r ? (~prod_s + {{WIDTH{1'b0}}, ONE_W}) : prod_s;
      final_res_s = ZERO_W;
      if (funct3_r[2]) begin
         final_res_s = funct3_r[1] ? neg_if(acc_nxt_s, neg_r_r) : neg_if(lo_nxt_s, neg_q_r);
      end else if (funct3_r[1:0] == 2'b00) begin
         final_res_s = prod_fix_s[WIDTH-1:0];
      end else begin
         final_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      end
   end

   // control FSM with datapath registers; reset beats flush, flush beats start/iteration
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         counter_r <= {CW{1'b0}};
         funct3_r  <= 3'b000;
         acc_r     <= ZERO_W;
         lo_r      <= ZERO_W;
         opb_r     <= ZERO_W;
         result_r  <= ZERO_W;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else if (flush) begin
         state_r   <= IDLE;
         counter_r <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  funct3_r  <= FUNCT3_EX;
                  counter_r <= {CW{1'b0}};
                  neg_q_r   <= sign_a_s ^ sign_b_s;
                  neg_r_r   <= sign_a_s;
                  acc_r     <= ZERO_W;
                  busy_r    <= 1'b1;
                  // divider shifts the dividend through lo_r; multiplier shifts OP_B
                  lo_r      <= is_div_s ? mag_a_s : mag_b_s;
                  opb_r     <= is_div_s ? mag_b_s : mag_a_s;
                  if (special_s) begin
                     result_r <= special_res_s;
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end else begin
                     state_r  <= CALC;
                  end
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            CALC: begin
               acc_r     <= acc_nxt_s;
               lo_r      <= lo_nxt_s;
               counter_r <= counter_r + {{(CW-1){1'b0}}, 1'b1};
               if (counter_r == LAST_IT) begin
                  result_r <= final_res_s;
                  done_r   <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  state_r  <= CALC;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r && !flush;
   assign RESULT   = result_r;
   assign stall_EX = ((state_r == IDLE) && start && !flush) || (state_r == CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, results, special cases,
// flush, reset mid-operation and start ignored while busy.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, flush, busy, done, stall_EX;
   logic [2:0]  f3;
   logic [31:0] a, b, result;
   int          n_tests = 0;
   int          n_fail  = 0;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .FUNCT3_EX(f3), .OP_A(a), .OP_B(b),
      .flush(flush), .busy(busy), .done(done), .RESULT(result), .stall_EX(stall_EX)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // start an op in cycle 0; optionally re-pulse start in cycle 'glitch' while busy
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] oa,
                         input logic [31:0] ob, input int lat, input logic [31:0] exp_res,
                         input int glitch);
      int   pulses = 0;
      int   first  = -1;
      logic stall_ok = 1'b1;
      @(negedge clk);
      f3 = op; a = oa; b = ob; start = 1'b1;
      #1;
      check({tag, "/stall0"}, {31'd0, stall_EX}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0; a = $urandom; b = $urandom; f3 = 3'($urandom);
      for (int cyc = 1; cyc <= lat + 2; cyc++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (first < 0) first = cyc;
         end
         if (cyc < lat && !stall_EX) stall_ok = 1'b0;
         if (cyc == lat) begin
            check({tag, "/result"}, result, exp_res);
            check({tag, "/stall_done"}, {31'd0, stall_EX}, 32'd0);
            check({tag, "/busy_done"}, {31'd0, busy}, 32'd1);
         end
         if (cyc == lat + 1) check({tag, "/busy_idle"}, {31'd0, busy}, 32'd0);
         start = (cyc == glitch);
         if (cyc == glitch) begin
            f3 = 3'b101; b = 32'd0;
         end
      end
      check({tag, "/pulses"}, 32'(pulses), 32'd1);
      check({tag, "/done_cycle"}, 32'(first), 32'(lat));
      check({tag, "/stall_calc"}, {31'd0, stall_ok}, 32'd1);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; start = 1'b0; flush = 1'b0; f3 = 3'b000; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst/busy", {31'd0, busy}, 32'd0);
      check("rst/done", {31'd0, done}, 32'd0);
      check("rst/result", result, 32'd0);
      check("rst/stall", {31'd0, stall_EX}, 32'd0);
      reset = 1'b0;

      // start together with flush is not accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; f3 = 3'b000; a = 32'd3; b = 32'd3;
      #1;
      check("flushstart/stall", {31'd0, stall_EX}, 32'd0);
      @(negedge clk);
      check("flushstart/busy", {31'd0, busy}, 32'd0);
      start = 1'b0; flush = 1'b0;

      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB, 0);
      run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 33, 32'h40000000, 0);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFF, 0);
      run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 0);
      run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, 0);
      run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 0);
      run_op("remu",   3'b111, 32'd100,      32'd7,        33, 32'd2,        0);
      run_op("divu_z", 3'b101, 32'h1234,     32'd0,        1,  32'hFFFFFFFF, 0);
      run_op("remu_z", 3'b111, 32'h1234,     32'd0,        1,  32'h1234,     0);
      run_op("rem_z",  3'b110, 32'hFFFFFFF9, 32'd0,        1,  32'hFFFFFFF9, 0);
      run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000, 0);
      run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1,  32'd0,        0);
      run_op("mul_gl", 3'b000, 32'd6,        32'd7,        33, 32'd42,       5);
      run_op("divu",   3'b101, 32'd100,      32'd7,        33, 32'd14,       0);

      // flush a DIVU in cycle 10; RESULT must keep 14
      pulses = 0;
      @(negedge clk);
      f3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (done) pulses++;
         if (cyc == 10) flush = 1'b1;
      end
      @(negedge clk);
      if (done) pulses++;
      flush = 1'b0;
      check("flush/busy", {31'd0, busy}, 32'd0);
      check("flush/stall", {31'd0, stall_EX}, 32'd0);
      check("flush/result", result, 32'd14);
      check("flush/pulses", 32'(pulses), 32'd0);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 33, 32'd15, 0);

      // reset in cycle 5 of a MUL
      pulses = 0;
      @(negedge clk);
      f3 = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstmid/busy", {31'd0, busy}, 32'd0);
      check("rstmid/result", result, 32'd0);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("rstmid/no_done", 32'(pulses), 32'd0);
      check("rstmid/result_hold", result, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
